// File: rtl/axi_lite_req_arbiter.sv
// Two-port arbiter in front of a single AXI4-Lite master command interface.
// It takes one transaction at a time and grants round-robin between the
// requesters. It drives the master's start/busy handshake and returns a
// completion pulse to the granted port. A saturating watchdog limits how
// long each wait phase may stall before the arbiter reports an error.
module axi_lite_req_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // Requester 0: core load/store unit
  input  logic                    r0_valid_i,
  input  logic                    r0_write_i,
  input  logic [ADDR_WIDTH-1:0]   r0_addr_i,
  input  logic [DATA_WIDTH-1:0]   r0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] r0_wstrb_i,
  output logic                    r0_ready_o,
  output logic                    r0_resp_valid_o,
  output logic [DATA_WIDTH-1:0]   r0_resp_rdata_o,
  output logic                    r0_resp_err_o,
  // Requester 1: debug/DMA port
  input  logic                    r1_valid_i,
  input  logic                    r1_write_i,
  input  logic [ADDR_WIDTH-1:0]   r1_addr_i,
  input  logic [DATA_WIDTH-1:0]   r1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] r1_wstrb_i,
  output logic                    r1_ready_o,
  output logic                    r1_resp_valid_o,
  output logic [DATA_WIDTH-1:0]   r1_resp_rdata_o,
  output logic                    r1_resp_err_o,
  // Master command interface
  output logic                    m_write_start_o,
  output logic [ADDR_WIDTH-1:0]   m_write_addr_o,
  output logic [DATA_WIDTH-1:0]   m_write_data_o,
  output logic [DATA_WIDTH/8-1:0] m_write_strobe_o,
  input  logic                    m_write_busy_i,
  output logic                    m_read_start_o,
  output logic [ADDR_WIDTH-1:0]   m_read_addr_o,
  input  logic [DATA_WIDTH-1:0]   m_read_data_i,
  input  logic                    m_read_busy_i
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned CntWidth  = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [StrbWidth-1:0]  cmd_wstrb_q, cmd_wstrb_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic any_valid;
  logic pick;
  logic sel_busy;
  logic [CntWidth-1:0] cnt_inc;

  assign any_valid = r0_valid_i | r1_valid_i;
  // On contention the port that did not win last time gets the grant.
  assign pick      = (r0_valid_i && r1_valid_i) ? ~last_grant_q : r1_valid_i;
  assign sel_busy  = cmd_write_q ? m_write_busy_i : m_read_busy_i;
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_wstrb_q  <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_wstrb_q  <= cmd_wstrb_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic: grant, command latch, handshake sequencing, watchdog.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_wstrb_d  = cmd_wstrb_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          grant_d      = pick;
          last_grant_d = pick;
          cmd_write_d  = pick ? r1_write_i : r0_write_i;
          cmd_addr_d   = pick ? r1_addr_i  : r0_addr_i;
          cmd_wdata_d  = pick ? r1_wdata_i : r0_wdata_i;
          cmd_wstrb_d  = pick ? r1_wstrb_i : r0_wstrb_i;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (sel_busy) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q >= CntLast) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StWaitDone: begin
        if (!sel_busy) begin
          err_d = 1'b0;
          if (!cmd_write_q) rdata_d = m_read_data_i;
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q >= CntLast) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode: qualified pulses per state, command fields straight from registers.
  always_comb begin
    r0_ready_o       = 1'b0;
    r1_ready_o       = 1'b0;
    r0_resp_valid_o  = 1'b0;
    r1_resp_valid_o  = 1'b0;
    r0_resp_err_o    = 1'b0;
    r1_resp_err_o    = 1'b0;
    r0_resp_rdata_o  = '0;
    r1_resp_rdata_o  = '0;
    m_write_start_o  = 1'b0;
    m_read_start_o   = 1'b0;
    m_write_addr_o   = cmd_addr_q;
    m_read_addr_o    = cmd_addr_q;
    m_write_data_o   = cmd_wdata_q;
    m_write_strobe_o = cmd_wstrb_q;
    unique case (state_q)
      StIdle: begin
        // Ready is combinational on valid, so mask it while reset is held.
        if (any_valid && !rst_i) begin
          r0_ready_o = ~pick;
          r1_ready_o = pick;
        end
      end
      StIssue: begin
        m_write_start_o = cmd_write_q;
        m_read_start_o  = ~cmd_write_q;
      end
      StResp: begin
        if (grant_q) begin
          r1_resp_valid_o = 1'b1;
          r1_resp_err_o   = err_q;
          if (!err_q && !cmd_write_q) r1_resp_rdata_o = rdata_q;
        end else begin
          r0_resp_valid_o = 1'b1;
          r0_resp_err_o   = err_q;
          if (!err_q && !cmd_write_q) r0_resp_rdata_o = rdata_q;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed bench for axi_lite_req_arbiter with a small behavioural master
// and word memory behind the command interface.
module tb_axi_lite_req_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_valid = 1'b0, r0_write = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic [3:0]    r0_wstrb = '0;
  logic          r0_ready, r0_resp_valid, r0_resp_err;
  logic [DW-1:0] r0_resp_rdata;
  logic          r1_valid = 1'b0, r1_write = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic [3:0]    r1_wstrb = '0;
  logic          r1_ready, r1_resp_valid, r1_resp_err;
  logic [DW-1:0] r1_resp_rdata;
  logic          m_write_start, m_read_start;
  logic [AW-1:0] m_write_addr, m_read_addr;
  logic [DW-1:0] m_write_data;
  logic [3:0]    m_write_strobe;
  logic          m_write_busy, m_read_busy;
  logic [DW-1:0] m_read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_req_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .r0_valid_i      (r0_valid),
    .r0_write_i      (r0_write),
    .r0_addr_i       (r0_addr),
    .r0_wdata_i      (r0_wdata),
    .r0_wstrb_i      (r0_wstrb),
    .r0_ready_o      (r0_ready),
    .r0_resp_valid_o (r0_resp_valid),
    .r0_resp_rdata_o (r0_resp_rdata),
    .r0_resp_err_o   (r0_resp_err),
    .r1_valid_i      (r1_valid),
    .r1_write_i      (r1_write),
    .r1_addr_i       (r1_addr),
    .r1_wdata_i      (r1_wdata),
    .r1_wstrb_i      (r1_wstrb),
    .r1_ready_o      (r1_ready),
    .r1_resp_valid_o (r1_resp_valid),
    .r1_resp_rdata_o (r1_resp_rdata),
    .r1_resp_err_o   (r1_resp_err),
    .m_write_start_o (m_write_start),
    .m_write_addr_o  (m_write_addr),
    .m_write_data_o  (m_write_data),
    .m_write_strobe_o(m_write_strobe),
    .m_write_busy_i  (m_write_busy),
    .m_read_start_o  (m_read_start),
    .m_read_addr_o   (m_read_addr),
    .m_read_data_i   (m_read_data),
    .m_read_busy_i   (m_read_busy)
  );

  // Behavioural master: busy rises the cycle after start and lasts lat_cfg cycles.
  logic [DW-1:0] mem [64];
  logic          disconnect = 1'b0;
  int            lat_cfg = 1;
  int            bcnt;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;

  always @(posedge clk) begin
    if (rst || disconnect) begin
      m_write_busy <= 1'b0;
      m_read_busy  <= 1'b0;
      bcnt         <= 0;
      if (rst) begin
        m_read_data <= '0;
        for (int i = 0; i < 64; i++) mem[i] <= '0;
      end
    end else begin
      if (m_write_start) begin
        m_write_busy <= 1'b1;
        bcnt         <= lat_cfg;
        wa           <= m_write_addr;
        wd           <= m_write_data;
      end else if (m_write_busy) begin
        if (bcnt <= 1) begin
          m_write_busy  <= 1'b0;
          mem[wa[7:2]]  <= wd;
        end else bcnt <= bcnt - 1;
      end
      if (m_read_start) begin
        m_read_busy <= 1'b1;
        bcnt        <= lat_cfg;
        ra          <= m_read_addr;
      end else if (m_read_busy) begin
        if (bcnt <= 1) begin
          m_read_busy <= 1'b0;
          m_read_data <= mem[ra[7:2]];
        end else bcnt <= bcnt - 1;
      end
    end
  end

  // Event monitor: pulse counts and the command seen with each start.
  int r0_rdy_cnt = 0, r1_rdy_cnt = 0, r0_resp_cnt = 0, r1_resp_cnt = 0;
  int wstart_cnt = 0, rstart_cnt = 0, overlap_cnt = 0;
  logic [AW-1:0] last_waddr = '0, last_raddr = '0;
  logic [3:0]    last_wstrb = '0;

  always @(posedge clk) begin
    if (r0_ready) r0_rdy_cnt <= r0_rdy_cnt + 1;
    if (r1_ready) r1_rdy_cnt <= r1_rdy_cnt + 1;
    if (r0_resp_valid) r0_resp_cnt <= r0_resp_cnt + 1;
    if (r1_resp_valid) r1_resp_cnt <= r1_resp_cnt + 1;
    if (m_write_start) begin
      wstart_cnt <= wstart_cnt + 1;
      last_waddr <= m_write_addr;
      last_wstrb <= m_write_strobe;
    end
    if (m_read_start) begin
      rstart_cnt <= rstart_cnt + 1;
      last_raddr <= m_read_addr;
    end
    if ((m_write_start || m_read_start) && (m_write_busy || m_read_busy))
      overlap_cnt <= overlap_cnt + 1;
  end

  task automatic apply_reset();
    rst = 1'b1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (p == 0) begin
      r0_valid = 1'b1; r0_write = w; r0_addr = a; r0_wdata = d; r0_wstrb = 4'hF;
    end else begin
      r1_valid = 1'b1; r1_write = w; r1_addr = a; r1_wdata = d; r1_wstrb = 4'hF;
    end
  endtask

  // Stimulus only: one request through to its completion, results handed back.
  task automatic do_req(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd,
                        output logic er, output int lat, output logic ok);
    int n;
    ok = 1'b0; rd = '0; er = 1'b0; lat = 0;
    set_req(p, w, a, d);
    #1;
    n = 0;
    while (!((p == 0) ? r0_ready : r1_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!((p == 0) ? r0_ready : r1_ready)) begin
      r0_valid = 1'b0; r1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (p == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
    lat = 1; n = 0;
    while (!((p == 0) ? r0_resp_valid : r1_resp_valid) && n < 100) begin
      @(posedge clk); #1; lat++; n++;
    end
    ok = (p == 0) ? r0_resp_valid : r1_resp_valid;
    rd = (p == 0) ? r0_resp_rdata : r1_resp_rdata;
    er = (p == 0) ? r0_resp_err : r1_resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    #1;
    checks++;
    if ({r0_ready, r1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 00", {r0_ready, r1_ready});
    end
    checks++;
    if ((|{r0_resp_valid, r1_resp_valid, r0_resp_err, r1_resp_err, m_write_start,
           m_read_start, r0_resp_rdata, r1_resp_rdata, m_write_addr, m_write_data,
           m_write_strobe, m_read_addr}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero, expected all 0");
    end
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ((wstart_cnt + rstart_cnt + r0_rdy_cnt + r1_rdy_cnt) !== 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d events expected 0",
               wstart_cnt + rstart_cnt + r0_rdy_cnt + r1_rdy_cnt);
    end
  endtask

  task automatic test_write_p0();
    logic [DW-1:0] rd; logic er, ok; int lat, rdy0, ws;
    rdy0 = r0_rdy_cnt; ws = wstart_cnt;
    do_req(0, 1'b1, 32'h04, 32'hAABBCCDD, rd, er, lat, ok);
    checks++;
    if (!ok || er !== 1'b0 || rd !== '0) begin
      errors++;
      $display("FAIL wr_p0_resp: ok=%b err=%b rdata=%h expected 1 0 0", ok, er, rd);
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL wr_p0_latency: got %0d expected 4", lat);
    end
    checks++;
    if (r0_rdy_cnt - rdy0 !== 1 || wstart_cnt - ws !== 1) begin
      errors++;
      $display("FAIL wr_p0_pulses: ready=%0d start=%0d expected 1 1",
               r0_rdy_cnt - rdy0, wstart_cnt - ws);
    end
    checks++;
    if (last_waddr !== 32'h04 || last_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL wr_p0_cmd: addr=%h strb=%h expected 4 f", last_waddr, last_wstrb);
    end
    checks++;
    if (mem[1] !== 32'hAABBCCDD) begin
      errors++; $display("FAIL wr_p0_mem: got %h expected aabbccdd", mem[1]);
    end
  endtask

  task automatic test_read_p1();
    logic [DW-1:0] rd; logic er, ok; int lat, r0r;
    r0r = r0_resp_cnt;
    do_req(1, 1'b0, 32'h04, 32'h0, rd, er, lat, ok);
    checks++;
    if (!ok || er !== 1'b0 || rd !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL rd_p1_resp: ok=%b err=%b rdata=%h expected 1 0 aabbccdd", ok, er, rd);
    end
    checks++;
    if (last_raddr !== 32'h04) begin
      errors++; $display("FAIL rd_p1_addr: got %h expected 4", last_raddr);
    end
    checks++;
    if (r0_resp_cnt !== r0r) begin
      errors++; $display("FAIL rd_p1_no_p0_resp: got %0d expected %0d", r0_resp_cnt, r0r);
    end
  endtask

  task automatic test_contention();
    int n, r0r;
    apply_reset();
    r0r = r0_resp_cnt;
    set_req(0, 1'b1, 32'h08, 32'h11223344);
    set_req(1, 1'b0, 32'h08, 32'h0);
    #1;
    checks++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL cont_first: r0/r1 ready=%b expected 10", {r0_ready, r1_ready});
    end
    // Port 0 re-requests at once, so the next grant is contended again.
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h08, 32'h0);
    n = 0;
    while (!(r0_ready || r1_ready) && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if ({r0_ready, r1_ready} !== 2'b01 || r0_resp_cnt - r0r !== 1) begin
      errors++;
      $display("FAIL cont_second: ready=%b p0_resps=%0d expected 01 1",
               {r0_ready, r1_ready}, r0_resp_cnt - r0r);
    end
    @(posedge clk); #1;
    r1_valid = 1'b0;
    n = 0;
    while (!r1_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (r1_resp_valid !== 1'b1 || r1_resp_rdata !== 32'h11223344 || r1_resp_err !== 1'b0) begin
      errors++;
      $display("FAIL cont_p1_data: valid=%b rdata=%h err=%b expected 1 11223344 0",
               r1_resp_valid, r1_resp_rdata, r1_resp_err);
    end
    n = 0;
    while (!r0_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    r0_valid = 1'b0;
    n = 0;
    while (!r0_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (r0_resp_valid !== 1'b1 || r0_resp_rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL cont_p0_read: valid=%b rdata=%h expected 1 11223344",
               r0_resp_valid, r0_resp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    logic [DW-1:0] rd; logic er, ok; int lat;
    disconnect = 1'b1;
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat, ok);
    checks++;
    if (!ok || er !== 1'b1 || rd !== '0) begin
      errors++;
      $display("FAIL timeout_resp: ok=%b err=%b rdata=%h expected 1 1 0", ok, er, rd);
    end
    // ready, issue, 8 wait-ack cycles, then resp.
    checks++;
    if (lat !== 10) begin
      errors++; $display("FAIL timeout_latency: got %0d expected 10", lat);
    end
    disconnect = 1'b0;
    do_req(0, 1'b0, 32'h08, 32'h0, rd, er, lat, ok);
    checks++;
    if (!ok || er !== 1'b0 || rd !== 32'h11223344 || lat !== 4) begin
      errors++;
      $display("FAIL timeout_recover: ok=%b err=%b rdata=%h lat=%0d expected 1 0 11223344 4",
               ok, er, rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic er, ok; int lat, n, r1r;
    lat_cfg = 6;
    set_req(1, 1'b0, 32'h08, 32'h0);
    #1;
    n = 0;
    while (!r1_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    r1_valid = 1'b0;
    n = 0;
    while (!m_read_busy && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    r1r = r1_resp_cnt;
    rst = 1'b1;
    r0_valid = 1'b1;
    #1;
    checks++;
    if ((|{r0_ready, r1_ready, r0_resp_valid, r1_resp_valid, r0_resp_err, r1_resp_err,
           m_write_start, m_read_start, r0_resp_rdata, r1_resp_rdata, m_write_addr,
           m_write_data, m_write_strobe, m_read_addr}) !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: read_addr=%h r1_resp=%b expected all 0",
               m_read_addr, r1_resp_valid);
    end
    r0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lat_cfg = 1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (r1_resp_cnt !== r1r) begin
      errors++; $display("FAIL midrst_no_resp: got %0d expected %0d", r1_resp_cnt, r1r);
    end
    do_req(0, 1'b1, 32'h0C, 32'h5555AAAA, rd, er, lat, ok);
    checks++;
    if (!ok || er !== 1'b0 || lat !== 4 || mem[3] !== 32'h5555AAAA) begin
      errors++;
      $display("FAIL midrst_after: ok=%b err=%b lat=%0d mem=%h expected 1 0 4 5555aaaa",
               ok, er, lat, mem[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] datas [3];
    int n, rdy0, rsp0;
    addrs[0] = 32'h00; addrs[1] = 32'h04; addrs[2] = 32'h08;
    datas[0] = 32'hCAFE0000; datas[1] = 32'hCAFE0004; datas[2] = 32'hCAFE0008;
    rdy0 = r0_rdy_cnt; rsp0 = r0_resp_cnt;
    set_req(0, 1'b1, addrs[0], datas[0]);
    #1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!r0_ready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      if (i < 2) set_req(0, 1'b1, addrs[i+1], datas[i+1]);
      else r0_valid = 1'b0;
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (r0_rdy_cnt - rdy0 !== 3 || r0_resp_cnt - rsp0 !== 3) begin
      errors++;
      $display("FAIL b2b_counts: ready=%0d resp=%0d expected 3 3",
               r0_rdy_cnt - rdy0, r0_resp_cnt - rsp0);
    end
    checks++;
    if (mem[0] !== datas[0] || mem[1] !== datas[1] || mem[2] !== datas[2]) begin
      errors++;
      $display("FAIL b2b_mem: got %h %h %h expected cafe0000 cafe0004 cafe0008",
               mem[0], mem[1], mem[2]);
    end
    checks++;
    if (overlap_cnt !== 0) begin
      errors++; $display("FAIL start_overlap: got %0d expected 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write_p0();
    test_read_p1();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
- Shares the single AXI4-Lite master command interface (write_start/read_start pulse, busy handshake) between two requesters.
- Port 0 is the core load/store unit; port 1 is the debug/DMA port.
- Accepts one transaction at a time, arbitrates round-robin, and sequences the master's start/busy protocol.
- Returns read data or completion to the granted requester, with a watchdog on stalled transfers.

Parameters:
- ADDR_WIDTH, 32, address width of requester and master command ports
- DATA_WIDTH, 32, data width
- TIMEOUT, 255, maximum cycles allowed in each wait phase before an error completion; must be ≥ 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rN_valid  in  1  request pending (N = 0, 1)
- rN_write  in  1  1 = write, 0 = read
- rN_addr  in  ADDR_WIDTH  transaction address
- rN_wdata  in  DATA_WIDTH  write data
- rN_wstrb  in  DATA_WIDTH/8  write byte strobes
- rN_ready  out  1  one-cycle accept pulse; command captured this cycle
- rN_resp_valid  out  1  one-cycle completion pulse
- rN_resp_rdata  out  DATA_WIDTH  read data; valid with rN_resp_valid
- rN_resp_err  out  1  timeout flag; valid with rN_resp_valid
- m_write_start  out  1  write start pulse to master
- m_write_addr  out  ADDR_WIDTH  write address to master
- m_write_data  out  DATA_WIDTH  write data to master
- m_write_strobe  out  DATA_WIDTH/8  write strobes to master
- m_write_busy  in  1  master write in progress
- m_read_start  out  1  read start pulse to master
- m_read_addr  out  ADDR_WIDTH  read address to master
- m_read_data  in  DATA_WIDTH  master read result; valid once m_read_busy falls
- m_read_busy  in  1  master read in progress

Behaviour:

Reset:
- All outputs 0; state IDLE; last_grant = 1, so port 0 wins the first contention; timeout counter 0.
- Reset asserted mid-transaction aborts immediately: no resp pulse is issued, and the command registers clear.

FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.

- IDLE:
  - If any rN_valid, pick the grant: sole requester; or, when both are valid, the port != last_grant.
  - Pulse rN_ready for that port and latch write/addr/wdata/wstrb into command registers.
  - Update last_grant and go to ISSUE.
  - Requesters hold all rN_* stable while rN_valid=1 and rN_ready=0; after the ready pulse they are free to change.
- ISSUE:
  - Pulse m_write_start or m_read_start (selected by latched write) for exactly one cycle.
  - Clear the counter; go to WAIT_ACK.
- WAIT_ACK:
  - Wait for the selected busy to be 1, then go to WAIT_DONE with the counter cleared.
  - Otherwise increment the counter. On reaching TIMEOUT, go to RESP with err=1.
- WAIT_DONE:
  - Wait for the selected busy to be 0, then go to RESP with err=0.
  - For reads, capture m_read_data on this same cycle.
  - Otherwise increment the counter. On reaching TIMEOUT, go to RESP with err=1.
- RESP:
  - Pulse rN_resp_valid for the granted port for one cycle.
  - rN_resp_rdata = captured data for reads, 0 for writes and for err=1.
  - rN_resp_err = err. Go to IDLE.
  - A new grant is possible on the next cycle.

Master command outputs:
- m_*_addr, m_write_data and m_write_strobe are driven from the command registers and held from ISSUE through RESP.
- They are 0 in IDLE after reset only; afterwards they keep their last values.
- Only the start pulses are qualified.

Ordering and latency:
- At most one outstanding transaction.
- Requests arriving during a busy transaction wait; they are not dropped.
- Minimum latency, ready to resp_valid: 4 cycles (ISSUE, WAIT_ACK, WAIT_DONE, RESP with one-cycle busy).

Boundary conditions:
- Simultaneous requests alternate grants.
- A requester that deasserts valid before ready is simply not granted.
- Busy already 1 on the WAIT_ACK entry cycle is accepted.
- The counter saturates and never wraps.

Test Plan:
- Port 0 write addr 0x04 data 0xAABBCCDD wstrb 0xF → r0_ready one cycle; m_write_start one pulse with addr 0x04; r0_resp_valid with err=0, rdata=0; memory word 0x04 = 0xAABBCCDD.
- Port 1 read of 0x04 after the above → m_read_start with addr 0x04; r1_resp_rdata = 0xAABBCCDD, err=0; port 0 sees no resp.
- Both ports valid on the same cycle from reset (r0 write 0x08=0x11223344, r1 read 0x08) → port 0 granted first, port 1 second; r1 rdata = 0x11223344. The next contention grants port 1 first.
- Master busy forced 0 (slave disconnected), port 0 read 0x10, TIMEOUT=8 → r0_resp_valid after 8 WAIT_ACK cycles with err=1, rdata=0; the arbiter returns to IDLE and serves the next request normally.
- rst asserted for 2 cycles while in WAIT_DONE of a port 1 read → all outputs 0 immediately; no r1_resp_valid; port 0 request after reset completes normally.
- Back-to-back port 0 writes with r0_valid held high (0x00, 0x04, 0x08) → three ready pulses, three resp pulses in order; no start pulse overlaps a busy period.
